// File: rtl/mult_div_unit_pkg.sv
// Shared MDU opcode encoding, sequencer states and the HI/LO arithmetic kernel.
// EX decode, ID hazard logic and the MDU all import this package.
package mult_div_unit_pkg;

    typedef enum logic [3:0] {
        OP_NONE  = 4'd0,
        OP_MULT  = 4'd1,
        OP_MULTU = 4'd2,
        OP_DIV   = 4'd3,
        OP_DIVU  = 4'd4,
        OP_MTHI  = 4'd5,
        OP_MTLO  = 4'd6,
        OP_MFHI  = 4'd7,
        OP_MFLO  = 4'd8
    } mdu_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_CALC = 1'b1
    } mdu_state_e;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
    } hilo_t;

    function automatic logic is_arith(input logic [3:0] op);
        return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
    endfunction

    function automatic logic is_divide(input logic [3:0] op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

    // Divide by zero yields '0 here; the caller suppresses the HI/LO commit anyway.
    function automatic hilo_t mdu_compute(input logic [3:0] op,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
        hilo_t              r;
        logic signed [63:0] sprod;
        logic [63:0]        uprod;
        r = '0;
        case (op)
            OP_MULT: begin
                sprod = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
                r     = hilo_t'(sprod);
            end
            OP_MULTU: begin
                uprod = {32'd0, a} * {32'd0, b};
                r     = hilo_t'(uprod);
            end
            OP_DIV: begin
                if (b == '0) begin
                    r = '0;
                end else if (a == 32'h8000_0000 && b == '1) begin
                    // The one signed quotient that overflows 32 bits wraps to itself.
                    r.lo = 32'h8000_0000;
                    r.hi = '0;
                end else begin
                    r.lo = $signed(a) / $signed(b);
                    r.hi = $signed(a) % $signed(b);
                end
            end
            OP_DIVU: begin
                if (b != '0) begin
                    r.lo = a / b;
                    r.hi = a % b;
                end
            end
            default: r = '0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/mult_div_unit_sequencer.sv
// mdu_sequencer: IDLE/CALC control with a down-counter that paces the busy window
// and emits a one-cycle done strobe on the final busy cycle.
module mdu_sequencer
    import mult_div_unit_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic is_div,
    output logic busy,
    output logic done
);

    localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CW         = $clog2(MAX_CYCLES + 1);

    mdu_state_e    state_q, state_d;
    logic [CW-1:0] count_q, count_d;
    logic          busy_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            count_q <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            busy_q  <= (state_d == ST_CALC);
        end
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        done    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_CALC;
                    count_d = is_div ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
                end
            end
            ST_CALC: begin
                if (count_q == CW'(1)) begin
                    done    = 1'b1;
                    state_d = ST_IDLE;
                    count_d = '0;
                end else begin
                    count_d = count_q - CW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign busy = busy_q;

endmodule

// File: rtl/mult_div_unit.sv
// Multi-cycle multiply/divide unit with architectural HI/LO, beside the EX-stage ALU.
// Results are staged in pend_hi/pend_lo at start and committed when the sequencer finishes.
module mult_div_unit
    import mult_div_unit_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  op,
    input  logic        op_valid,
    input  logic [31:0] rs,
    input  logic [31:0] rt,
    output logic        start,
    output logic        busy,
    output logic [31:0] read_data
);

    logic [31:0] hi_q, lo_q;
    logic [31:0] pend_hi, pend_lo;
    logic        pend_div0;
    logic        is_div;
    logic        done;
    hilo_t       result;

    assign is_div = is_divide(op);
    assign start  = op_valid & is_arith(op) & ~busy;
    assign result = mdu_compute(op, rs, rt);

    mdu_sequencer #(
        .MULT_CYCLES (MULT_CYCLES),
        .DIV_CYCLES  (DIV_CYCLES)
    ) u_seq (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .is_div (is_div),
        .busy   (busy),
        .done   (done)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hi_q      <= '0;
            lo_q      <= '0;
            pend_hi   <= '0;
            pend_lo   <= '0;
            pend_div0 <= 1'b0;
        end else begin
            if (start) begin
                pend_hi   <= result.hi;
                pend_lo   <= result.lo;
                pend_div0 <= is_div && (rt == '0);
            end
            // done only occurs while busy, so it never collides with a move.
            if (done) begin
                if (!pend_div0) begin
                    hi_q <= pend_hi;
                    lo_q <= pend_lo;
                end
            end else if (op_valid && !busy) begin
                if (op == OP_MTHI) hi_q <= rs;
                if (op == OP_MTLO) lo_q <= rs;
            end
        end
    end

    assign read_data = (op == OP_MFHI) ? hi_q : lo_q;

endmodule
